ram_dq: RTL and testbench

//  Single-port synchronous RAM, one shared address bus, separate data-in/data-out (DQ).

---
 rtl/ram_dq_pkg.sv | 40 ++++
 rtl/ram_dq_outreg.sv | 29 ++
 rtl/ram_dq.sv | 112 +++++++++++
 tb/tb_ram_dq.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/ram_dq_pkg.sv
// ram_dq_pkg
//   Shared types and helpers for the ram_dq single-port RAM.
//   - regmode_e : output pipeline depth (NOREG = 1-cycle read, REG = 2-cycle read)
//   - wmode_e   : Q behaviour on a write cycle (NORMAL hold, WTHRU new data, RBW old data)
//   - helper functions map the string parameters to the enums and validate them.
package ram_dq_pkg;

    typedef enum logic {
        NOREG = 1'b0,
        REG   = 1'b1
    } regmode_e;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        WTHRU  = 2'd1,
        RBW    = 2'd2
    } wmode_e;

    function automatic logic regmode_valid(input string s);
        return (s == "noreg") || (s == "reg");
    endfunction

    function automatic logic wmode_valid(input string s);
        return (s == "normal") || (s == "writethrough") || (s == "readbeforewrite");
    endfunction

    // Unknown strings fall back to the default encoding; the top module
    // rejects them at elaboration before this value can matter.
    function automatic regmode_e to_regmode(input string s);
        if (s == "reg") return REG;
        return NOREG;
    endfunction

    function automatic wmode_e to_wmode(input string s);
        if (s == "writethrough")    return WTHRU;
        if (s == "readbeforewrite") return RBW;
        return NORMAL;
    endfunction

endpackage

// File: rtl/ram_dq_outreg.sv
// ram_dq_outreg
//   Optional second output stage of ram_dq (REGMODE = "reg").
// Ports:
//   Clock    in   rising-edge clock
//   Reset    in   synchronous active-high reset, clears the stage
//   ClockEn  in   global enable, 0 holds the stage
//   d        in   DATA_WIDTH  data from the first read stage
//   q        out  DATA_WIDTH  registered output
module ram_dq_outreg
    import ram_dq_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ClockEn,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            q <= '0;
        end else if (ClockEn) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ram_dq.sv
// ram_dq
//   Single-port synchronous RAM with one shared address bus and separate
//   data-in / data-out. Behavioural model of the vendor EBR single-port
//   primitive; used as the backing store of the stack blocks.
// Parameters (positional order): ADDR_DEPTH, ADDR_WIDTH, DATA_WIDTH, REGMODE, WRITE_MODE
//   REGMODE    "noreg" | "reg"
//   WRITE_MODE "normal" | "writethrough" | "readbeforewrite"
// Ports:
//   Clock    in   rising-edge clock
//   Reset    in   synchronous active-high; clears Q and the pipeline stage, not the array
//   ClockEn  in   global enable; 0 freezes the array and all output registers
//   WE       in   write enable
//   Address  in   ADDR_WIDTH  word address for read and write
//   Data     in   DATA_WIDTH  write data
//   Q        out  DATA_WIDTH  registered read data
// Build option:
//   RAM_DQ_ZERO_INIT_EN  when defined, every word starts at zero; otherwise
//                        contents are X until written.
module ram_dq
    import ram_dq_pkg::*;
#(
    parameter int    ADDR_DEPTH = 64,
    parameter int    ADDR_WIDTH = 6,
    parameter int    DATA_WIDTH = 32,
    parameter string REGMODE    = "noreg",
    parameter string WRITE_MODE = "normal"
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ClockEn,
    input  logic                  WE,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] Data,
    output logic [DATA_WIDTH-1:0] Q
);

    localparam regmode_e RM    = to_regmode(REGMODE);
    localparam wmode_e   WM    = to_wmode(WRITE_MODE);
    localparam int       IDX_W = (ADDR_DEPTH > 1) ? $clog2(ADDR_DEPTH) : 1;

    generate
        if (!regmode_valid(REGMODE)) begin : g_bad_regmode
            $fatal(1, "ram_dq: illegal REGMODE string");
        end
        if (!wmode_valid(WRITE_MODE)) begin : g_bad_wmode
            $fatal(1, "ram_dq: illegal WRITE_MODE string");
        end
        if (ADDR_WIDTH < IDX_W) begin : g_bad_width
            $fatal(1, "ram_dq: ADDR_WIDTH too small for ADDR_DEPTH");
        end
    endgenerate

`ifdef RAM_DQ_ZERO_INIT_EN
    logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH] = '{default: '0};
`else
    logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];
`endif

    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] q_core;

    // Depth need not be a power of two, so the full address is range-checked;
    // out-of-range accesses never alias onto a real word.
    assign in_range = (int'(Address) < ADDR_DEPTH);
    assign idx      = Address[IDX_W-1:0];
    assign rd_word  = in_range ? mem[idx] : '0;

    // Array kept free of reset so it maps onto block RAM; a write that
    // coincides with Reset is dropped here rather than by a reset branch.
    always_ff @(posedge Clock) begin
        if (!Reset && ClockEn && WE && in_range) begin
            mem[idx] <= Data;
        end
    end

    // First read stage. rd_word is sampled before the array NBA lands,
    // which is what gives read-before-write its old-data result.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            q_core <= '0;
        end else if (ClockEn) begin
            if (WE) begin
                if (WM == WTHRU) begin
                    q_core <= Data;
                end else if (WM == RBW) begin
                    q_core <= rd_word;
                end
            end else begin
                q_core <= rd_word;
            end
        end
    end

    generate
        if (RM == REG) begin : g_outreg
            ram_dq_outreg #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_outreg (
                .Clock  (Clock),
                .Reset  (Reset),
                .ClockEn(ClockEn),
                .d      (q_core),
                .q      (Q)
            );
        end else begin : g_noreg
            assign Q = q_core;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dq.sv
module tb_ram_dq;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] qn, qr, qw, qb, qs;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ram_dq #(64, 6, 32, "noreg", "normal") u_norm (
        .Clock(clk), .Reset(rst), .ClockEn(ce), .WE(we), .Address(addr), .Data(data), .Q(qn));
    ram_dq #(64, 6, 32, "reg", "normal") u_reg (
        .Clock(clk), .Reset(rst), .ClockEn(ce), .WE(we), .Address(addr), .Data(data), .Q(qr));
    ram_dq #(64, 6, 32, "noreg", "writethrough") u_wthru (
        .Clock(clk), .Reset(rst), .ClockEn(ce), .WE(we), .Address(addr), .Data(data), .Q(qw));
    ram_dq #(64, 6, 32, "noreg", "readbeforewrite") u_rbw (
        .Clock(clk), .Reset(rst), .ClockEn(ce), .WE(we), .Address(addr), .Data(data), .Q(qb));
    ram_dq #(48, 6, 32, "noreg", "normal") u_small (
        .Clock(clk), .Reset(rst), .ClockEn(ce), .WE(we), .Address(addr), .Data(data), .Q(qs));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic w,
                         input logic [5:0] a, input logic [31:0] d);
        rst = r; ce = e; we = w; addr = a; data = d;
    endtask

    initial begin
        // Reset
        drive(1, 1, 0, 6'd0, 32'h0);
        tick();
        check("rst_qn", qn, 32'h0);
        check("rst_qr", qr, 32'h0);
        check("rst_qw", qw, 32'h0);
        check("rst_qb", qb, 32'h0);

        // Write 0x12345678 @5, then read it back
        drive(0, 1, 1, 6'd5, 32'h1234_5678);
        tick();
        check("wr5_normal_hold", qn, 32'h0);
        check("wr5_wthru", qw, 32'h1234_5678);
        drive(0, 1, 0, 6'd5, 32'h0);
        tick();
        check("rd5_noreg", qn, 32'h1234_5678);
        check("rd5_reg_first_edge", qr, 32'h0);
        check("rd5_rbw", qb, 32'h1234_5678);

        // ClockEn low with a pending write: nothing moves
        drive(0, 0, 1, 6'd5, 32'hFFFF_FFFF);
        tick();
        check("ce0_qn_hold", qn, 32'h1234_5678);
        check("ce0_qr_hold", qr, 32'h0);
        drive(0, 1, 0, 6'd5, 32'h0);
        tick();
        check("ce0_mem_kept", qn, 32'h1234_5678);
        check("rd5_reg_second_edge", qr, 32'h1234_5678);

        // REGMODE=reg latency with 0xDEADBEEF @63
        drive(0, 1, 1, 6'd63, 32'hDEAD_BEEF);
        tick();
        drive(0, 1, 0, 6'd63, 32'h0);
        tick();
        check("rd63_noreg", qn, 32'hDEAD_BEEF);
        check("rd63_reg_intermediate", qr, 32'h1234_5678);
        drive(0, 1, 0, 6'd5, 32'h0);
        tick();
        check("rd63_reg_two_edges", qr, 32'hDEAD_BEEF);
        check("rd5_noreg_again", qn, 32'h1234_5678);

        // Write-mode sweep: 0xAAAA0001 over 0x00000007 @10
        drive(0, 1, 1, 6'd10, 32'h0000_0007);
        tick();
        drive(0, 1, 0, 6'd10, 32'h0);
        tick();
        check("rd10_pre_rbw", qb, 32'h0000_0007);
        drive(0, 1, 1, 6'd10, 32'hAAAA_0001);
        tick();
        check("wmode_normal", qn, 32'h0000_0007);
        check("wmode_wthru", qw, 32'hAAAA_0001);
        check("wmode_rbw", qb, 32'h0000_0007);
        drive(0, 1, 0, 6'd10, 32'h0);
        tick();
        check("rd10_after_write", qn, 32'hAAAA_0001);

        // Stack pattern: push 10 @63, push 20 @62, pop 62 then 63
        drive(0, 1, 1, 6'd63, 32'd10);
        tick();
        drive(0, 1, 1, 6'd62, 32'd20);
        tick();
        drive(0, 1, 0, 6'd62, 32'h0);
        tick();
        check("pop62", qn, 32'd20);
        check("small_oor_rd62", qs, 32'h0);
        drive(0, 1, 0, 6'd63, 32'h0);
        tick();
        check("pop63", qn, 32'd10);
        check("small_oor_rd63", qs, 32'h0);

        // Non-power-of-two depth: last legal word and an ignored write
        drive(0, 1, 1, 6'd47, 32'h0BAD_F00D);
        tick();
        drive(0, 1, 1, 6'd50, 32'h5555_5555);
        tick();
        drive(0, 1, 0, 6'd47, 32'h0);
        tick();
        check("small_rd47", qs, 32'h0BAD_F00D);
        drive(0, 1, 0, 6'd50, 32'h0);
        tick();
        check("small_rd50_ignored", qs, 32'h0);

        // Reset mid-read
        drive(1, 1, 0, 6'd5, 32'h0);
        tick();
        check("midrst_qn", qn, 32'h0);
        check("midrst_qr", qr, 32'h0);
        drive(0, 1, 0, 6'd5, 32'h0);
        tick();
        check("postrst_qn", qn, 32'h1234_5678);
        check("postrst_qr_stage_cleared", qr, 32'h0);
        tick();
        check("postrst_qr", qr, 32'h1234_5678);

        // A write coinciding with Reset is dropped
        drive(1, 1, 1, 6'd5, 32'h0000_0BAD);
        tick();
        drive(0, 1, 0, 6'd5, 32'h0);
        tick();
        check("rst_drops_write", qn, 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
